// File: rtl/triangle_traversal.sv
// Triangle traversal: scans a triangle's bounding box row-major and emits covered pixels.
// Coverage uses a 3-stage barycentric pipeline with full-stall backpressure.
module triangle_traversal #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic         clk,
  input  logic         rst,
  // {v0x,v0y,e0x,e0y,e1x,e1y}[20b Q16.3 each], {d00,d01,d11}[40b each],
  // {bbox_min_x,bbox_min_y,bbox_max_x,bbox_max_y}[16b each], MSB first
  input  logic [303:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [15:0]  out_x,
  output logic [15:0]  out_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         tri_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [15:0] X_LAST = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(HEIGHT - 1);

  function automatic logic [15:0] clamp16(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_e        state_q, state_d;
  logic [303:0]  tri_q, tri_d;
  logic [15:0]   x_q, x_d, y_q, y_d;

  logic                s1_valid_q, s2_valid_q, s3_valid_q, s3_inside_q;
  logic [15:0]         s1_x_q, s1_y_q, s2_x_q, s2_y_q, s3_x_q, s3_y_q;
  logic signed [41:0]  s1_d20_q, s1_d21_q;
  logic signed [81:0]  s2_vnum_q, s2_wnum_q, s2_den_q;

  logic signed [19:0]  v0x_s, v0y_s, e0x_s, e0y_s, e1x_s, e1y_s;
  logic signed [39:0]  d00_s, d01_s, d11_s;
  logic [15:0]         min_x_s, min_y_s, max_x_s, max_y_s;
  logic signed [20:0]  qx_s, qy_s;
  logic signed [41:0]  d20_s, d21_s;
  logic signed [81:0]  vnum_s, wnum_s, den_s;
  logic signed [82:0]  vw_sum_s;
  logic                inside_s, advance_s, pipe_empty_s;

  assign v0x_s = tri_q[303:284];
  assign v0y_s = tri_q[283:264];
  assign e0x_s = tri_q[263:244];
  assign e0y_s = tri_q[243:224];
  assign e1x_s = tri_q[223:204];
  assign e1y_s = tri_q[203:184];
  assign d00_s = tri_q[183:144];
  assign d01_s = tri_q[143:104];
  assign d11_s = tri_q[103:64];

  // Scan range is clipped to the screen so an off-screen bbox cannot run the counters away
  assign min_x_s = clamp16(tri_q[63:48], X_LAST);
  assign min_y_s = clamp16(tri_q[47:32], Y_LAST);
  assign max_x_s = clamp16(tri_q[31:16], X_LAST);
  assign max_y_s = clamp16(tri_q[15:0],  Y_LAST);

  // A held fragment freezes the scanner and every stage so order is preserved
  assign advance_s    = !(s3_valid_q && s3_inside_q && !out_ready);
  assign pipe_empty_s = !s1_valid_q && !s2_valid_q && !s3_valid_q;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_x     = s3_x_q;
  assign out_y     = s3_y_q;
  assign out_valid = s3_valid_q && s3_inside_q;

  // Control state, captured triangle and scan counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tri_q   <= 304'd0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Next-state, scan stepping and completion pulse
  always_comb begin
    state_d  = state_q;
    tri_d    = tri_q;
    x_d      = x_q;
    y_d      = y_q;
    tri_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = SCAN;
          tri_d   = in_state;
          x_d     = clamp16(in_state[63:48], X_LAST);
          y_d     = clamp16(in_state[47:32], Y_LAST);
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (advance_s) begin
          if (x_q == max_x_s) begin
            x_d = min_x_s;
            if (y_q == max_y_s) begin
              state_d = DRAIN;
            end else begin
              y_d = y_q + 16'd1;
            end
          end else begin
            x_d = x_q + 16'd1;
          end
        end else begin
          state_d = SCAN;
        end
      end
      DRAIN: begin
        if (pipe_empty_s) begin
          state_d  = IDLE;
          tri_done = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pixel centre relative to v0, projected onto both edges
  always_comb begin
    qx_s  = $signed({2'b00, x_q, 3'b100}) - 21'(v0x_s);
    qy_s  = $signed({2'b00, y_q, 3'b100}) - 21'(v0y_s);
    d20_s = 42'(qx_s) * 42'(e0x_s) + 42'(qy_s) * 42'(e0y_s);
    d21_s = 42'(qx_s) * 42'(e1x_s) + 42'(qy_s) * 42'(e1y_s);
  end

  // Unnormalised barycentrics; den==0 marks a degenerate triangle
  always_comb begin
    vnum_s   = 82'(d11_s) * 82'(s1_d20_q) - 82'(d01_s) * 82'(s1_d21_q);
    wnum_s   = 82'(d00_s) * 82'(s1_d21_q) - 82'(d01_s) * 82'(s1_d20_q);
    den_s    = 82'(d00_s) * 82'(d11_s)    - 82'(d01_s) * 82'(d01_s);
    vw_sum_s = 83'(s2_vnum_q) + 83'(s2_wnum_q);
    inside_s = (s2_den_q != 82'sd0) && !s2_vnum_q[81] && !s2_wnum_q[81] &&
               (vw_sum_s <= 83'(s2_den_q));
  end

  // Three-stage coverage pipeline, advancing only when the output is not held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= 16'd0;
      s1_y_q      <= 16'd0;
      s1_d20_q    <= 42'sd0;
      s1_d21_q    <= 42'sd0;
      s2_valid_q  <= 1'b0;
      s2_x_q      <= 16'd0;
      s2_y_q      <= 16'd0;
      s2_vnum_q   <= 82'sd0;
      s2_wnum_q   <= 82'sd0;
      s2_den_q    <= 82'sd0;
      s3_valid_q  <= 1'b0;
      s3_inside_q <= 1'b0;
      s3_x_q      <= 16'd0;
      s3_y_q      <= 16'd0;
    end else if (advance_s) begin
      s1_valid_q  <= (state_q == SCAN);
      s1_x_q      <= x_q;
      s1_y_q      <= y_q;
      s1_d20_q    <= d20_s;
      s1_d21_q    <= d21_s;
      s2_valid_q  <= s1_valid_q;
      s2_x_q      <= s1_x_q;
      s2_y_q      <= s1_y_q;
      s2_vnum_q   <= vnum_s;
      s2_wnum_q   <= wnum_s;
      s2_den_q    <= den_s;
      s3_valid_q  <= s2_valid_q;
      s3_inside_q <= inside_s;
      s3_x_q      <= s2_x_q;
      s3_y_q      <= s2_y_q;
    end
  end

endmodule

// File: doc/triangle_traversal.md
TRIANGLE_TRAVERSAL -- requirements
Module: triangle_traversal

Interface
REQ-001 SHALL have parameter WIDTH, default 320, screen width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 240, screen height in pixels.
REQ-003 SHALL have port clk, input, 1, clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_state, input, triangle_state_t, triangle setup record: v0x/v0y/e0x/e0y/e1x/e1y Q16.3, d00/d01/d11, bbox.
REQ-006 SHALL have port in_valid, input, 1, in_state is valid.
REQ-007 SHALL have port in_ready, output, 1, block accepts a triangle.
REQ-008 SHALL have port out_x, output, 16, fragment pixel x (unsigned integer).
REQ-009 SHALL have port out_y, output, 16, fragment pixel y (unsigned integer).
REQ-010 SHALL have port out_valid, output, 1, fragment valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts fragment.
REQ-012 SHALL have port tri_done, output, 1, one-cycle pulse: triangle fully traversed.
REQ-013 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, DRAIN; in_ready = (state==IDLE).
REQ-015 IDLE->SCAN on in_valid && in_ready; in_state captured into an internal register that cycle; scan counters load x=bbox_min_x, y=bbox_min_y.
REQ-016 SCAN issues one candidate pixel per unstalled cycle, row-major: x increments to bbox_max_x, then x wraps to bbox_min_x and y increments.
REQ-017 SCAN->DRAIN when pixel (bbox_max_x, bbox_max_y) is issued; single-pixel bbox (min==max both axes) issues exactly one pixel.
REQ-018 DRAIN->IDLE when all pipeline stages are empty; tri_done pulses high for exactly that transition cycle.
REQ-019 Candidate point p = pixel center in Q16.3: px = (x<<3)+4, py = (y<<3)+4; qx = px - v0x, qy = py - v0y, 21-bit signed.
REQ-020 Pipeline stage 1 SHALL register d20 = qx*e0x + qy*e0y and d21 = qx*e1x + qy*e1y, 42-bit signed.
REQ-021 Stage 2 SHALL register vnum = d11*d20 - d01*d21, wnum = d00*d21 - d01*d20, and den = d00*d11 - d01*d01, all 82-bit signed, no truncation.
REQ-022 Stage 3 SHALL register inside = (den != 0) && vnum>=0 && wnum>=0 && (vnum+wnum)<=den; out_valid = stage-3 valid && inside.
REQ-023 Outside pixels are discarded silently; they consume a pipeline slot but never assert out_valid.
REQ-024 Latency: pixel issued in cycle k appears on out_x/out_y with out_valid in cycle k+3 absent stalls; throughput 1 pixel/cycle.
REQ-025 Stall = out_valid && !out_ready; while stalled, scan counters and all pipeline stages hold; out_x, out_y, out_valid stay stable.
REQ-026 Fragment transfers on out_valid && out_ready; fragment order matches issue order.
REQ-027 Degenerate triangle (den==0) SHALL emit zero fragments, still complete the scan and pulse tri_done.
REQ-028 A new triangle SHALL NOT be accepted until tri_done; the next triangle's fragments never interleave with the previous triangle's.

Reset
REQ-029 On rst: state=IDLE, all pipeline valid bits 0, scan counters 0, captured triangle 0.
REQ-030 Reset outputs: in_ready=1, out_valid=0, out_x=0, out_y=0, tri_done=0, busy=0.
REQ-031 rst asserted mid-SCAN or mid-DRAIN SHALL abort traversal; no fragment or tri_done emitted for that triangle after release.

Verification
REQ-032 Triangle v0=(0,0), v1=(4,0), v2=(0,4) px, bbox 0..4 both axes, out_ready=1 -> exactly 10 fragments (x+y<=3) in row-major order, first (0,0) 3 cycles after first issue, then tri_done.
REQ-033 Collinear v0=(0,0), v1=(2,2), v2=(4,4) -> 25 pixels scanned, zero out_valid, one tri_done pulse.
REQ-034 Same as REQ-032 with out_ready low 5 cycles while first fragment valid -> out_x=0, out_y=0, out_valid=1 held all 5 cycles; total 10 fragments, none lost or duplicated.
REQ-035 Bbox min=max=(7,9) with pixel covered -> exactly one fragment (7,9), tri_done; in_ready=0 from accept until tri_done cycle.
REQ-036 rst pulse after 6 pixels issued in REQ-032 -> out_valid=0, in_ready=1 immediately; no tri_done; next triangle traverses correctly.
REQ-037 Back-to-back triangles with in_valid held high -> second accepted the cycle after first tri_done; fragments never mixed.
